// File: rtl/captura_pkg.sv
// captura_pkg: shared state encoding and data width for the input-capture stage
package captura_pkg;
    localparam int DATA_W = 4;
    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_PRESS   = 2'b01;
    localparam logic [1:0] S_HOLD    = 2'b10;
    localparam logic [1:0] S_RELEASE = 2'b11;
    typedef enum logic [1:0] {
        IDLE    = S_IDLE,
        PRESS   = S_PRESS,
        HOLD    = S_HOLD,
        RELEASE = S_RELEASE
    } state_t;
endpackage

// File: rtl/captura_entrada_sincronizador.sv
// sincronizador: multi-flop synchroniser for asynchronous input lines
module sincronizador #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    // shift raw lines through the flop chain, cleared on reset
    always_ff @(posedge clk_i) begin
        if (rst_i) stage_q <= '0;
        else       stage_q <= {stage_q[STAGES-2:0], d_i};
    end
    assign q_o = stage_q[STAGES-1];
endmodule

// File: rtl/captura_entrada.sv
// captura_entrada: synchronise switches and load button, debounce, latch data with ready/overrun
module captura_entrada
    import captura_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] switches_i,
    input  logic              load_i,
    input  logic              clear_i,
    output logic [DATA_W-1:0] data_o,
    output logic              ready_o,
    output logic              overrun_o,
    output logic              busy_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic [DATA_W:0]   sync_s;
    logic [DATA_W-1:0] sw_s, data_q, data_d;
    logic              load_s, ready_q, ready_d, overrun_q, overrun_d, capture, cnt_max;
    logic [CW-1:0]     cnt_q, cnt_d;
    state_t            state_q, state_d;

    sincronizador #(.WIDTH(DATA_W + 1), .STAGES(SYNC_STAGES)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   ({load_i, switches_i}),
        .q_o   (sync_s)
    );

    assign sw_s    = sync_s[DATA_W-1:0];
    assign load_s  = sync_s[DATA_W];
    assign cnt_max = cnt_q == CW'(DEBOUNCE_CYCLES - 1);

    // debounce FSM next state plus capture-driven output register updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE:    if (load_s) begin state_d = PRESS; cnt_d = '0; end
            PRESS:   if (!load_s) state_d = IDLE;
                     else if (cnt_max) begin capture = 1'b1; state_d = HOLD; end
                     else cnt_d = cnt_q + 1'b1;
            HOLD:    if (!load_s) begin state_d = RELEASE; cnt_d = '0; end
            RELEASE: if (load_s) state_d = HOLD;
                     else if (cnt_max) state_d = IDLE;
                     else cnt_d = cnt_q + 1'b1;
            default: state_d = IDLE;
        endcase
        data_d    = capture ? sw_s : data_q;
        ready_d   = capture | (ready_q & ~clear_i);
        overrun_d = clear_i ? 1'b0 : overrun_q | (capture & ready_q);
    end

    // state, counter and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o    = data_q;
    assign ready_o   = ready_q;
    assign overrun_o = overrun_q;
    assign busy_o    = state_q != IDLE;
endmodule

// File: tb/tb_captura_entrada.sv
// tb_captura_entrada: scoreboard bench for the debounced input-capture stage
module tb_captura_entrada;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] switches = 4'b0000;
    logic       load = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] data;
    logic       ready, overrun, busy;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        int         c;
        string      name;
        logic [3:0] d;
        logic       r;
        logic       o;
        logic       b;
    } exp_t;
    exp_t sb[$];

    captura_entrada #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .switches_i(switches),
        .load_i    (load),
        .clear_i   (clear),
        .data_o    (data),
        .ready_o   (ready),
        .overrun_o (overrun),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int c, input string n, input logic [3:0] d,
                             input logic r, input logic o, input logic b);
        sb.push_back('{c, n, d, r, o, b});
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // monitor: pop every expectation due at this cycle and compare with DUT outputs
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].c <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.c < cyc) begin
                errors++;
                $display("FAIL %s: expectation for edge %0d missed at edge %0d", e.name, e.c, cyc);
            end else if ({data, ready, overrun, busy} !== {e.d, e.r, e.o, e.b}) begin
                errors++;
                $display("FAIL %s @edge %0d: got data=%b ready=%b overrun=%b busy=%b, want data=%b ready=%b overrun=%b busy=%b",
                         e.name, cyc, data, ready, overrun, busy, e.d, e.r, e.o, e.b);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        expect_at(2, "reset", 4'b0000, 0, 0, 0);
        wait_cyc(2);
        rst = 1'b0;

        expect_at(11, "a_idle_before_press", 4'b0000, 0, 0, 0);
        expect_at(12, "a_busy_press", 4'b0000, 0, 0, 1);
        expect_at(15, "a_not_yet_ready", 4'b0000, 0, 0, 1);
        expect_at(16, "a_capture", 4'b1010, 1, 0, 1);
        wait_cyc(9);
        switches = 4'b1010;
        load = 1'b1;

        expect_at(23, "b_bounce_hold", 4'b1010, 1, 0, 1);
        expect_at(28, "b_release_last", 4'b1010, 1, 0, 1);
        expect_at(29, "b_release_idle", 4'b1010, 1, 0, 0);
        wait_cyc(20); load = 1'b0;
        wait_cyc(21); load = 1'b1;
        wait_cyc(22); load = 1'b0;

        expect_at(37, "c_before_capture", 4'b1010, 1, 0, 1);
        expect_at(38, "c_overrun_capture", 4'b0110, 1, 1, 1);
        expect_at(40, "c_overrun_sticky", 4'b0110, 1, 1, 1);
        expect_at(41, "c_clear", 4'b0110, 0, 0, 1);
        expect_at(45, "c_data_held", 4'b0110, 0, 0, 1);
        expect_at(51, "c_release_last", 4'b0110, 0, 0, 1);
        expect_at(52, "c_release_idle", 4'b0110, 0, 0, 0);
        wait_cyc(30); switches = 4'b0110;
        wait_cyc(31); load = 1'b1;
        wait_cyc(40); clear = 1'b1;
        wait_cyc(41); clear = 1'b0;
        wait_cyc(45); load = 1'b0;

        expect_at(62, "d_glitch_press", 4'b0110, 0, 0, 1);
        expect_at(64, "d_glitch_cnt2", 4'b0110, 0, 0, 1);
        expect_at(65, "d_glitch_abort", 4'b0110, 0, 0, 0);
        expect_at(68, "d_no_capture", 4'b0110, 0, 0, 0);
        wait_cyc(59); switches = 4'b1001; load = 1'b1;
        wait_cyc(62); load = 1'b0;

        expect_at(76, "e_first_capture", 4'b0011, 1, 0, 1);
        expect_at(84, "e_idle_ready", 4'b0011, 1, 0, 0);
        expect_at(95, "e_before_clr_cap", 4'b0011, 1, 0, 1);
        expect_at(96, "e_clear_and_capture", 4'b1111, 1, 0, 1);
        expect_at(99, "e_clear_after", 4'b1111, 0, 0, 1);
        wait_cyc(69); switches = 4'b0011; load = 1'b1;
        wait_cyc(77); load = 1'b0;
        wait_cyc(89); switches = 4'b1111; load = 1'b1;
        wait_cyc(95); clear = 1'b1;
        wait_cyc(96); clear = 1'b0;
        wait_cyc(98); clear = 1'b1;
        wait_cyc(99); clear = 1'b0;

        expect_at(107, "f_idle", 4'b1111, 0, 0, 0);
        expect_at(114, "f_press_cnt2", 4'b1111, 0, 0, 1);
        expect_at(115, "f_reset_mid_press", 4'b0000, 0, 0, 0);
        expect_at(117, "f_resync_idle", 4'b0000, 0, 0, 0);
        expect_at(118, "f_fresh_press", 4'b0000, 0, 0, 1);
        expect_at(121, "f_not_yet_ready", 4'b0000, 0, 0, 1);
        expect_at(122, "f_fresh_capture", 4'b0101, 1, 0, 1);
        expect_at(126, "f_held_no_recapture", 4'b0101, 1, 0, 1);
        wait_cyc(100); load = 1'b0;
        wait_cyc(109); load = 1'b1;
        wait_cyc(110); switches = 4'b0101;
        wait_cyc(114); rst = 1'b1;
        wait_cyc(115); rst = 1'b0;
        wait_cyc(123); switches = 4'b1100;

        wait_cyc(128);
        @(negedge clk);
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: expectation for edge %0d never checked", e.name, e.c);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/captura_entrada.md
Name: captura_entrada

Overview:
- Upstream input-capture stage for the 4-bit combinational encoder.
- Synchronises four raw switch lines and a raw "load" pushbutton, then debounces the button.
- On a clean press, latches the switch value and raises a level Ready flag.
- Output Data/Ready drive the encoder's Input/Ready directly. Ready holds until Clear or Reset; Overrun flags a press that replaces unconsumed data.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised cycles required for press and for release; legal range is 2 or more.
- SYNC_STAGES, 2: synchroniser flop depth for Switches and Load; legal range is 2 or more.

Ports:
- Clock  in  1  single system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high; overrides every other input.
- Switches  in  4  raw asynchronous switch lines.
- Load  in  1  raw asynchronous pushbutton, active high.
- Clear  in  1  synchronous consumer acknowledge; drops Ready and Overrun.
- Data  out  4  captured switch value; feeds the encoder Input[3:0].
- Ready  out  1  level; Data is valid; feeds the encoder Ready.
- Overrun  out  1  sticky; a capture occurred while Ready was already 1.
- Busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset, sampled high at an edge, sets the following on the next edge:
  - Data=0, Ready=0, Overrun=0, state=IDLE, counter=0.
  - Synchroniser flops are cleared to 0.
  - Reset mid-debounce abandons the press; no capture occurs.
- Synchronisers: Switches and Load each pass through SYNC_STAGES flops, giving sw_s and load_s. No other logic reads the raw pins.
- Counter: width $clog2(DEBOUNCE_CYCLES); it never wraps past DEBOUNCE_CYCLES-1.
- FSM states: IDLE=2'b00, PRESS=2'b01, HOLD=2'b10, RELEASE=2'b11.
- IDLE:
  - load_s=1 goes to PRESS with cnt=0.
  - Otherwise stays in IDLE.
- PRESS:
  - load_s=0 goes to IDLE; this is a glitch, with no capture.
  - load_s=1 with cnt<N-1 increments cnt.
  - load_s=1 with cnt==N-1 is a capture: Data<=sw_s and Ready<=1, go to HOLD.
  - On capture with Ready already 1 and Clear=0, also set Overrun<=1.
- HOLD: stays while load_s=1; load_s=0 goes to RELEASE with cnt=0.
- RELEASE:
  - load_s=1 returns to HOLD; this is bounce, and the release count restarts.
  - cnt==N-1 with load_s=0 goes to IDLE.
  - Otherwise increments cnt.
- Latency: Load held high from rising-edge k (first sampling edge) gives Ready=1 after edge k+SYNC_STAGES+DEBOUNCE_CYCLES.
  - Defaults: edge k+18.
- One capture per press: a held button never re-captures; a full debounced release is required first.
- Clear: Ready<=0 and Overrun<=0 on the next edge. Data is unchanged, and the value is held indefinitely.
- Clear and capture on the same edge: capture wins. Ready=1 with new Data, and Overrun is cleared, not set.
- Busy = (state != IDLE), decoded combinationally from the state register.
- Switches are expected stable during the press. Data takes sw_s exactly at the capture edge.

Decomposition:
- Package captura_pkg holds:
  - the state encoding localparams S_IDLE, S_PRESS, S_HOLD, S_RELEASE;
  - the data-width constant DATA_W=4.
- One sub-module, sincronizador:
  - parameters WIDTH and STAGES; synchronous active-high reset to 0.
  - Instantiated once for {Load, Switches} with WIDTH=5.
- The FSM, counter and output registers stay in captura_entrada.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Switches=4'b1010 with Load high from edge 10 → Ready=1 and Data=4'b1010 after edge 16. Busy=1 from edge 12. Overrun=0.
- Load high for 3 cycles only (edges 10-12) → PRESS aborts, Ready stays 0, Data stays 0, back to IDLE.
- Release bounce: after capture, toggle Load 1-0-1-0 with 1-cycle spacing, then hold low → no second capture, IDLE only after 4 stable low synchronised cycles, Ready remains 1.
- Second full press with Switches=4'b0110 and no Clear → Data=4'b0110, Ready=1, Overrun=1. Then Clear for 1 cycle → Ready=0 and Overrun=0 next edge, Data=4'b0110 held.
- Clear asserted on the exact capture edge → Ready=1 with new Data, Overrun=0.
- Reset high for 1 edge while in PRESS (cnt=2) → all outputs 0 and IDLE next edge. Load still held high → a fresh capture after 2+4 further edges.
